// File: rtl/dense_layer_sequencer.sv
// rtl/dense_layer_sequencer.sv - dense layer MAC sequencer with bias add and arg-max
module dense_layer_sequencer #(
    parameter int N_IN     = 128,
    parameter int N_OUT    = 10,
    parameter int W_BITS   = 4,
    parameter int F_BITS   = 8,
    parameter int ACC_BITS = 20,
    localparam int FA      = $clog2(N_IN),
    localparam int WA      = $clog2(N_IN * N_OUT),
    localparam int OA      = $clog2(N_OUT)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    output logic [FA-1:0]       feat_addr,
    input  logic [F_BITS-1:0]   feat_data,
    output logic [WA-1:0]       w_addr,
    input  logic [W_BITS-1:0]   w_data,
    output logic [OA-1:0]       bias_sel,
    input  logic [W_BITS-1:0]   bias_data,
    output logic                busy,
    output logic                logit_valid,
    output logic [OA-1:0]       logit_idx,
    output logic [ACC_BITS-1:0] logit_data,
    output logic [OA-1:0]       class_out,
    output logic                done
);

    // Product width: unsigned feature widened by one sign bit times signed weight.
    localparam int PW = F_BITS + W_BITS + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_BIAS,
        S_FINISH
    } state_t;

    state_t                      state, state_nxt;
    logic [FA-1:0]               f_cnt;
    logic [OA-1:0]               o_cnt;
    logic [WA-1:0]               wa_cnt;
    logic                        issue_v;
    logic signed [ACC_BITS-1:0]  acc;
    logic signed [ACC_BITS-1:0]  best_val;
    logic [OA-1:0]               best_idx;
    logic [OA-1:0]               class_q;

    logic                        f_last;
    logic                        o_last;
    logic signed [PW-1:0]        feat_ext;
    logic signed [PW-1:0]        w_ext;
    logic signed [PW-1:0]        prod;
    logic signed [ACC_BITS-1:0]  prod_ext;
    logic signed [ACC_BITS-1:0]  bias_ext;
    logic signed [ACC_BITS-1:0]  logit_sum;
    logic                        take_best;

    assign f_last    = (f_cnt == FA'(N_IN - 1));
    assign o_last    = (o_cnt == OA'(N_OUT - 1));
    assign feat_ext  = {{(PW - F_BITS){1'b0}}, feat_data};
    assign w_ext     = {{(PW - W_BITS){w_data[W_BITS-1]}}, w_data};
    assign prod      = feat_ext * w_ext;
    assign prod_ext  = {{(ACC_BITS - PW){prod[PW-1]}}, prod};
    assign bias_ext  = {{(ACC_BITS - W_BITS){bias_data[W_BITS-1]}}, bias_data};
    assign logit_sum = acc + bias_ext;
    // Strictly greater keeps the lower index on ties; class 0 always seeds the search.
    assign take_best = (o_cnt == '0) || (logit_sum > best_val);
    assign class_out = class_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and per-state outputs; addresses are zero outside their states.
    always_comb begin
        state_nxt   = state;
        busy        = 1'b0;
        feat_addr   = '0;
        w_addr      = '0;
        bias_sel    = '0;
        logit_valid = 1'b0;
        logit_idx   = '0;
        logit_data  = '0;
        done        = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                busy      = 1'b1;
                feat_addr = f_cnt;
                w_addr    = wa_cnt;
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (f_last) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy      = 1'b1;
                state_nxt = abort ? S_IDLE : S_BIAS;
            end
            S_BIAS: begin
                busy        = 1'b1;
                bias_sel    = o_cnt;
                logit_idx   = o_cnt;
                logit_data  = logit_sum;
                logit_valid = !abort;
                if (abort) begin
                    state_nxt = S_IDLE;
                end else begin
                    state_nxt = o_last ? S_FINISH : S_ISSUE;
                end
            end
            S_FINISH: begin
                done      = !abort;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Counters, accumulator and arg-max tracking. The weight address runs contiguously
    // across classes since o*N_IN+f just steps by one from the last feature of one
    // class to the first feature of the next.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_cnt    <= '0;
            o_cnt    <= '0;
            wa_cnt   <= '0;
            issue_v  <= 1'b0;
            acc      <= '0;
            best_val <= '0;
            best_idx <= '0;
            class_q  <= '0;
        end else if (abort && (state != S_IDLE)) begin
            f_cnt    <= '0;
            o_cnt    <= '0;
            wa_cnt   <= '0;
            issue_v  <= 1'b0;
            acc      <= '0;
            best_val <= '0;
            best_idx <= '0;
        end else begin
            // Read data lags the address by one cycle, so the issue flag is delayed to match.
            issue_v <= (state == S_ISSUE);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        f_cnt    <= '0;
                        o_cnt    <= '0;
                        wa_cnt   <= '0;
                        acc      <= '0;
                        best_val <= '0;
                        best_idx <= '0;
                    end
                end
                S_ISSUE: begin
                    f_cnt  <= f_cnt + 1'b1;
                    wa_cnt <= wa_cnt + 1'b1;
                    if (issue_v) begin
                        acc <= acc + prod_ext;
                    end
                end
                S_DRAIN: begin
                    if (issue_v) begin
                        acc <= acc + prod_ext;
                    end
                end
                S_BIAS: begin
                    acc <= '0;
                    if (take_best) begin
                        best_val <= logit_sum;
                        best_idx <= o_cnt;
                    end
                    if (o_last) begin
                        class_q <= take_best ? o_cnt : best_idx;
                    end else begin
                        o_cnt <= o_cnt + 1'b1;
                        f_cnt <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dense_layer_sequencer.sv
// tb/tb_dense_layer_sequencer.sv - scoreboard bench for dense_layer_sequencer
module tb_dense_layer_sequencer;

    localparam int N_IN  = 128;
    localparam int N_OUT = 10;
    localparam int CLS   = N_IN + 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic               abort = 1'b0;
    logic [6:0]         feat_addr;
    logic [7:0]         feat_data;
    logic [10:0]        w_addr;
    logic signed [3:0]  w_data;
    logic [3:0]         bias_sel;
    logic signed [3:0]  bias_data;
    logic               busy;
    logic               logit_valid;
    logic [3:0]         logit_idx;
    logic signed [19:0] logit_data;
    logic [3:0]         class_out;
    logic               done;

    logic [7:0]         feat_mem [N_IN];
    logic signed [3:0]  w_mem    [N_IN*N_OUT];
    logic signed [3:0]  bias_mem [N_OUT];

    dense_layer_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .feat_addr   (feat_addr),
        .feat_data   (feat_data),
        .w_addr      (w_addr),
        .w_data      (w_data),
        .bias_sel    (bias_sel),
        .bias_data   (bias_data),
        .busy        (busy),
        .logit_valid (logit_valid),
        .logit_idx   (logit_idx),
        .logit_data  (logit_data),
        .class_out   (class_out),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Synchronous-read memories, combinational bias table.
    always @(posedge clk) begin
        feat_data <= feat_mem[feat_addr];
        w_data    <= w_mem[w_addr];
    end
    assign bias_data = bias_mem[bias_sel];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int idx;
        int data;
    } logit_t;

    logit_t lq[$];
    int     dq[$];
    logit_t le;
    int     de;
    int     e0 = 0;
    int     done_cnt = 0;
    int     addr_err = 0;
    bit     addr_chk = 1'b0;
    int     ta, ra, ca, ef, ew, eb;

    // Monitor: pops expected logits and results whenever the DUT presents them.
    always @(negedge clk) begin
        if (rst_n && logit_valid) begin
            if (lq.size() == 0) begin
                chk("unexpected_logit", 1, 0);
            end else begin
                le = lq.pop_front();
                chk("logit_idx", int'(logit_idx), le.idx);
                chk("logit_data", int'(logit_data), le.data);
                chk("logit_time", cyc - e0 + 1, (le.idx + 1) * CLS);
            end
        end
        if (rst_n && done) begin
            if (dq.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                de = dq.pop_front();
                chk("class_out", int'(class_out), de);
                chk("done_time", cyc - e0 + 1, N_OUT * CLS + 1);
                chk("busy_at_done", int'(busy), 0);
            end
            done_cnt++;
        end
    end

    // Address walk: feature f / weight o*N_IN+f during issue, bias index during the bias cycle.
    always @(negedge clk) begin
        if (addr_chk && rst_n) begin
            ta = cyc - e0;
            if (ta < N_OUT * CLS) begin
                ca = ta / CLS;
                ra = ta % CLS;
                ef = (ra < N_IN) ? ra : 0;
                ew = (ra < N_IN) ? ca * N_IN + ra : 0;
                eb = (ra == N_IN + 1) ? ca : 0;
                if (int'(feat_addr) != ef || int'(w_addr) != ew || int'(bias_sel) != eb || busy !== 1'b1)
                    addr_err++;
            end
        end
    end

    task automatic load(input int fv, input int wv, input int wcls, input int bconst, input bit bramp);
        for (int i = 0; i < N_IN; i++) feat_mem[i] = 8'(fv);
        for (int i = 0; i < N_IN * N_OUT; i++)
            w_mem[i] = (wcls < 0 || (i / N_IN) == wcls) ? 4'(wv) : 4'sd0;
        for (int o = 0; o < N_OUT; o++) bias_mem[o] = bramp ? 4'(o - 5) : 4'(bconst);
    endtask

    task automatic push_logit(input int idx, input int data);
        logit_t t;
        t.idx  = idx;
        t.data = data;
        lq.push_back(t);
    endtask

    task automatic launch(input bit with_abort, input bit hold_start);
        @(negedge clk);
        start = 1'b1;
        abort = with_abort;
        @(negedge clk);
        if (!hold_start) start = 1'b0;
        abort    = 1'b0;
        e0       = cyc;
        addr_err = 0;
        addr_chk = 1'b1;
        chk("busy_after_start", int'(busy), 1);
    endtask

    task automatic wait_done(input string name);
        int n0;
        int k;
        n0 = done_cnt;
        k  = 0;
        while (done_cnt == n0 && k < N_OUT * CLS + 50) begin
            @(negedge clk);
            k++;
        end
        chk({name, "_done_seen"}, int'(done_cnt != n0), 1);
        addr_chk = 1'b0;
        chk({name, "_addr_seq"}, addr_err, 0);
        chk({name, "_queue_empty"}, lq.size(), 0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_logit_valid"}, int'(logit_valid), 0);
        chk({tag, "_logit_idx"}, int'(logit_idx), 0);
        chk({tag, "_logit_data"}, int'(logit_data), 0);
        chk({tag, "_class_out"}, int'(class_out), 0);
        chk({tag, "_feat_addr"}, int'(feat_addr), 0);
        chk({tag, "_w_addr"}, int'(w_addr), 0);
        chk({tag, "_bias_sel"}, int'(bias_sel), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        int n0;
        load(0, 0, -1, 0, 1'b0);
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Zero features: logit equals bias, ramp -5..4, best is the last class.
        load(0, -3, -1, 0, 1'b1);
        for (int o = 0; o < N_OUT; o++) push_logit(o, o - 5);
        dq.push_back(9);
        launch(1'b0, 1'b0);
        wait_done("zero_feat");

        // All ones: every logit 128, tie resolves to class 0.
        load(1, 1, -1, 0, 1'b0);
        for (int o = 0; o < N_OUT; o++) push_logit(o, 128);
        dq.push_back(0);
        launch(1'b0, 1'b0);
        wait_done("all_ones");

        // Extreme negative: 128*255*(-8) - 8.
        load(255, -8, -1, -8, 1'b0);
        for (int o = 0; o < N_OUT; o++) push_logit(o, -261128);
        dq.push_back(0);
        launch(1'b0, 1'b0);
        wait_done("extreme_neg");

        // Only class 3 has weights: 128*10 = 1280.
        load(10, 1, 3, 0, 1'b0);
        for (int o = 0; o < N_OUT; o++) push_logit(o, (o == 3) ? 1280 : 0);
        dq.push_back(3);
        launch(1'b0, 1'b0);
        wait_done("class3");

        // Abort at cycle 400: classes 0..2 already emitted, then nothing.
        for (int o = 0; o < 3; o++) push_logit(o, 0);
        n0 = done_cnt;
        launch(1'b0, 1'b0);
        repeat (399) @(negedge clk);
        addr_chk = 1'b0;
        chk("abort_addr_seq", addr_err, 0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy_low", int'(busy), 0);
        repeat (1400) @(negedge clk);
        chk("abort_no_done", done_cnt, n0);
        chk("abort_queue_empty", lq.size(), 0);
        chk("abort_class_kept", int'(class_out), 3);

        // Start and abort together in IDLE: start wins, full correct run follows.
        load(0, -3, -1, 0, 1'b1);
        for (int o = 0; o < N_OUT; o++) push_logit(o, o - 5);
        dq.push_back(9);
        launch(1'b1, 1'b0);
        wait_done("start_wins");

        // Start held while busy is ignored; reset mid-issue clears everything at once.
        load(1, 1, -1, 0, 1'b0);
        launch(1'b0, 1'b1);
        repeat (60) @(negedge clk);
        addr_chk = 1'b0;
        chk("held_start_addr_seq", addr_err, 0);
        rst_n = 1'b0;
        #1;
        check_zero("midreset");
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midreset_queue_empty", lq.size(), 0);

        // Recovery after reset.
        load(10, 1, 3, 0, 1'b0);
        for (int o = 0; o < N_OUT; o++) push_logit(o, (o == 3) ? 1280 : 0);
        dq.push_back(3);
        launch(1'b0, 1'b0);
        wait_done("after_reset");

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
